disp_capture: RTL and testbench
===============================

// Module: disp_capture
// PURPOSE
//  Receiving end of the 4-digit multiplexed 7-segment display interface driven by xtop (Disp/Disp_sel).
//  Samples the scanned segment/anode lines, decodes each digit back to a hex nibble and assembles a
//  16-bit value. Publishes the value only after identical full frames repeat, giving benches and
//  loopback tests a cycle-clean readout of what the display shows.
// PARAMETERS
//  SETTLE_CYC     4   cycles disp_sel must be stable before the digit is sampled (>=1)
//  STABLE_FRAMES  2   consecutive identical frames needed before value is published (>=1)
// PORTS
//  clk       in   1   system clock, all logic on rising edge
//  rst       in   1   asynchronous, active-high reset
//  disp      in   8   segments, active-low, {dp,g,f,e,d,c,b,a}
//  disp_sel  in   4   anodes, active-low one-hot; bit i selects digit i (bit 3 = most significant)
//  value     out  16  published value, digit i in value[4i+3:4i]
//  dp        out  4   published decimal points, 1 = lit
//  seg_err   out  4   published per-digit flag: pattern not in hex table (includes blank)
//  valid     out  1   a value has been published since reset
//  update    out  1   one-cycle pulse when value/dp/seg_err are (re)written
// BEHAVIOUR
//  Reset: value=0, dp=0, seg_err=0, valid=0, update=0; input regs=8'hFF/4'hF; counters, bitmap, frame buffers 0.
//  Input stage: disp/disp_sel registered once (1 cycle); all logic below uses the registered copy.
//  Select legality: legal iff exactly one disp_sel bit is 0. Illegal (all 1, multiple 0) -> counter
//    cleared, no sample, FSM to WAIT.
//  FSM per digit window:
//   WAIT   : on legal sel -> SETTLE, settle_cnt=1.
//   SETTLE : sel equal to previous cycle -> settle_cnt++; on settle_cnt==SETTLE_CYC sample digit, -> HELD.
//            sel changes to another legal value -> settle_cnt=1, stay SETTLE; illegal -> WAIT.
//   HELD   : no further sample while sel unchanged; sel change -> SETTLE (legal) or WAIT (illegal).
//  Sample latency: SETTLE_CYC + 1 cycles after new sel appears at the pin.
//  Sample: nibble/err from seg7_decode of disp[6:0], dp = ~disp[7], written to work slot i;
//    captured bitmap bit i set. Re-sampling a digit before the frame completes overwrites slot i.
//  Frame complete: cycle after bitmap == 4'hF. Then bitmap cleared; work frame {nibble,dp,err}x4
//    compared with last frame:
//   equal     -> match_cnt = min(match_cnt+1, STABLE_FRAMES); different -> match_cnt=1; last := work.
//   Publish when match_cnt reaches STABLE_FRAMES and (valid==0 or frame != published):
//    value/dp/seg_err written, valid=1, update=1 for that cycle only. Same frame repeating: no update.
//  Mismatching frame after publish: outputs hold, valid stays 1 until reset.
//  Frame complete and a new sample in the same cycle: sample goes into the freshly cleared bitmap.
//  Decode table (gfedcba, active-low): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10
//    A:08 b:03 C:46 d:21 E:06 F:0E. Any other code (blank 7F incl.) -> nibble 0, err 1.
//  rst asserted mid-frame: all state to reset values immediately; first frame after starts fresh.
// STRUCTURE
//  Shared package (xdefs.vh): SEG_* decode constants, DISP_DIGITS=4, disp FSM state encodings.
//  Sub-module seg7_decode: purely combinational 7-bit pattern -> {err, nibble[3:0]}.
//  Top: input regs, select legality, FSM + settle counter, work/last frames, match counter, publish.
// TESTING
//  1) Scan 1234 (sel E,D,B,7 -> digits 4,3,2,1; codes 19,30,24,79), SETTLE_CYC+2 cycles/digit,
//     3 frames -> single update pulse after frame 2, value=16'h1234, valid=1, seg_err=0.
//  2) Same scan with sel held only SETTLE_CYC-1 cycles/digit -> no sample, valid stays 0.
//  3) Stable 16'hABCD then switch to 16'h00F0 -> one pulse per value, value holds ABCD for one
//     mismatching frame, then 00F0 after STABLE_FRAMES frames.
//  4) Digit 2 shows 7F (blank), dp lit on digit 0 -> seg_err=4'b0100, value[11:8]=0, dp=4'b0001.
//  5) Insert sel=4'hF and 4'hC glitches between digits -> no samples during glitches, value unaffected.
//  6) Assert rst mid-frame after valid -> outputs 0 next cycle, republish needs STABLE_FRAMES full frames.

Source files
------------

// File: rtl/disp_capture_pkg.sv
// Shared definitions for the 7-segment display capture block: segment codes, FSM encodings,
// frame record type and select-line helpers.
package disp_capture_pkg;

  localparam int unsigned DISP_DIGITS = 4;

  // Active-low gfedcba patterns
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  localparam logic [1:0] StWait   = 2'd0;
  localparam logic [1:0] StSettle = 2'd1;
  localparam logic [1:0] StHeld   = 2'd2;

  typedef struct packed {
    logic [4*DISP_DIGITS-1:0] value;
    logic [DISP_DIGITS-1:0]   dp;
    logic [DISP_DIGITS-1:0]   err;
  } frame_t;

  function automatic logic sel_legal(logic [DISP_DIGITS-1:0] sel);
    return $countones(~sel) == 1;
  endfunction

  // Position of the (single) low anode bit; only meaningful when sel_legal().
  function automatic logic [1:0] sel_index(logic [DISP_DIGITS-1:0] sel);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < DISP_DIGITS; i++) begin
      if (!sel[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/disp_capture_if.sv
// Scanned display lines (driven by the display source) and the published readout.
interface disp_capture_if;
  logic [7:0]  disp;
  logic [3:0]  disp_sel;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  seg_err;
  logic        valid;
  logic        update;

  modport master (
    output disp, disp_sel,
    input  value, dp, seg_err, valid, update
  );

  modport slave (
    input  disp, disp_sel,
    output value, dp, seg_err, valid, update
  );
endinterface

// File: rtl/disp_capture_seg7_decode.sv
// Combinational 7-segment pattern to hex nibble decoder; unknown patterns (blank included)
// give nibble 0 with err set.
module disp_capture_seg7_decode
  import disp_capture_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       err
);

  always_comb begin
    nibble = 4'h0;
    err    = 1'b0;
    case (seg)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/disp_capture.sv
// Captures a scanned 4-digit 7-segment display and publishes the decoded value once the same
// full frame has been seen STABLE_FRAMES times in a row.
module disp_capture
  import disp_capture_pkg::*;
#(
  parameter int unsigned SETTLE_CYC    = 4,
  parameter int unsigned STABLE_FRAMES = 2
) (
  input logic           clk,
  input logic           rst,
  disp_capture_if.slave bus
);

  localparam int unsigned CntW   = $clog2(SETTLE_CYC + 1);
  localparam int unsigned MatchW = $clog2(STABLE_FRAMES + 1);

  logic [7:0]        disp_q;
  logic [3:0]        sel_q, sel_prev_q;
  logic [1:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [3:0]        bitmap_q, bitmap_d;
  logic [MatchW-1:0] match_q, match_d;
  frame_t            work_q, work_d, last_q, last_d, pub_q;
  logic              valid_q, update_q;

  logic              legal, changed, sample, frame_done, publish;
  logic [1:0]        idx;
  logic [3:0]        nibble;
  logic              seg_err;

  disp_capture_seg7_decode u_decode (
    .seg    (disp_q[6:0]),
    .nibble (nibble),
    .err    (seg_err)
  );

  assign legal      = sel_legal(sel_q);
  assign changed    = sel_q != sel_prev_q;
  assign idx        = sel_index(sel_q);
  assign frame_done = bitmap_q == 4'hF;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sample  = 1'b0;
    unique case (state_q)
      StWait: begin
        if (legal) begin
          state_d = StSettle;
          cnt_d   = CntW'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      StSettle: begin
        if (!legal) begin
          state_d = StWait;
          cnt_d   = '0;
        end else if (changed) begin
          cnt_d   = CntW'(1);
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      StHeld: begin
        if (!legal) begin
          state_d = StWait;
          cnt_d   = '0;
        end else if (changed) begin
          state_d = StSettle;
          cnt_d   = CntW'(1);
        end
      end
      default: begin
        state_d = StWait;
        cnt_d   = '0;
      end
    endcase
    // Reaching the settle count samples on this edge, which also covers SETTLE_CYC == 1.
    if (state_d == StSettle && cnt_d == CntW'(SETTLE_CYC)) begin
      sample  = 1'b1;
      state_d = StHeld;
    end
  end

  always_comb begin
    work_d   = work_q;
    bitmap_d = frame_done ? 4'h0 : bitmap_q;
    if (sample) begin
      work_d.value[{idx, 2'b00} +: 4] = nibble;
      work_d.dp[idx]                  = ~disp_q[7];
      work_d.err[idx]                 = seg_err;
      bitmap_d[idx]                   = 1'b1;
    end
  end

  always_comb begin
    match_d = match_q;
    last_d  = last_q;
    publish = 1'b0;
    if (frame_done) begin
      last_d = work_q;
      if (work_q == last_q) begin
        match_d = (match_q >= MatchW'(STABLE_FRAMES)) ? MatchW'(STABLE_FRAMES) : match_q + 1'b1;
      end else begin
        match_d = MatchW'(1);
      end
      publish = (match_d == MatchW'(STABLE_FRAMES)) && (!valid_q || work_q != pub_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_q     <= 8'hFF;
      sel_q      <= 4'hF;
      sel_prev_q <= 4'hF;
      state_q    <= StWait;
      cnt_q      <= '0;
      bitmap_q   <= '0;
      work_q     <= '0;
      last_q     <= '0;
      match_q    <= '0;
      pub_q      <= '0;
      valid_q    <= 1'b0;
      update_q   <= 1'b0;
    end else begin
      disp_q     <= bus.disp;
      sel_q      <= bus.disp_sel;
      sel_prev_q <= sel_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitmap_q   <= bitmap_d;
      work_q     <= work_d;
      last_q     <= last_d;
      match_q    <= match_d;
      update_q   <= publish;
      if (publish) begin
        pub_q   <= work_q;
        valid_q <= 1'b1;
      end
    end
  end

  assign bus.value   = pub_q.value;
  assign bus.dp      = pub_q.dp;
  assign bus.seg_err = pub_q.err;
  assign bus.valid   = valid_q;
  assign bus.update  = update_q;

endmodule

// File: tb/tb_disp_capture.sv
// Directed bench for disp_capture: scans whole display frames from a vector table and checks
// publish pulses and the published readout, plus glitch and mid-frame reset sequences.
module tb_disp_capture;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  disp_capture_if bus ();

  disp_capture #(
    .SETTLE_CYC    (4),
    .STABLE_FRAMES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int upd_total = 0;

  always @(negedge clk) if (bus.update === 1'b1) upd_total <= upd_total + 1;

  typedef struct {
    logic [15:0] val;
    logic [3:0]  dpl;
    logic [3:0]  blank;
    int          frames;
    int          hold;
    bit          glitch;
    int          exp_upd;
    logic        exp_valid;
    logic [15:0] exp_value;
    logic [3:0]  exp_dp;
    logic [3:0]  exp_err;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] enc(input logic [3:0] n, input logic dp_on, input logic blank);
    logic [6:0] c;
    case (n)
      4'h0: c = 7'h40;  4'h1: c = 7'h79;  4'h2: c = 7'h24;  4'h3: c = 7'h30;
      4'h4: c = 7'h19;  4'h5: c = 7'h12;  4'h6: c = 7'h02;  4'h7: c = 7'h78;
      4'h8: c = 7'h00;  4'h9: c = 7'h10;  4'hA: c = 7'h08;  4'hB: c = 7'h03;
      4'hC: c = 7'h46;  4'hD: c = 7'h21;  4'hE: c = 7'h06;  default: c = 7'h0E;
    endcase
    if (blank) c = 7'h7F;
    return {~dp_on, c};
  endfunction

  task automatic drive(input logic [3:0] sel, input logic [7:0] code, input int hold);
    bus.disp_sel = sel;
    bus.disp     = code;
    repeat (hold) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(4'hF, 8'hFF, n);
  endtask

  task automatic scan(input logic [15:0] v, input logic [3:0] dpl, input logic [3:0] blank,
                      input int frames, input int hold, input bit glitch);
    for (int f = 0; f < frames; f++) begin
      for (int d = 0; d < 4; d++) begin
        drive(~(4'b0001 << d), enc(v[4*d +: 4], dpl[d], blank[d]), hold);
        if (glitch) begin
          drive(4'hF, 8'h00, 2);
          drive(4'hC, 8'h00, 6);
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag, input logic vld, input logic [15:0] val,
                               input logic [3:0] dp, input logic [3:0] err);
    check({tag, ".valid"}, 32'(bus.valid), 32'(vld));
    check({tag, ".value"}, 32'(bus.value), 32'(val));
    check({tag, ".dp"}, 32'(bus.dp), 32'(dp));
    check({tag, ".seg_err"}, 32'(bus.seg_err), 32'(err));
  endtask

  initial begin
    int u0;
    string tag;

    vecs[0] = '{16'h1234, 4'h0, 4'h0, 3, 3, 1'b0, 0, 1'b0, 16'h0000, 4'h0, 4'h0};
    vecs[1] = '{16'h1234, 4'h0, 4'h0, 3, 6, 1'b0, 1, 1'b1, 16'h1234, 4'h0, 4'h0};
    vecs[2] = '{16'hABCD, 4'h0, 4'h0, 2, 6, 1'b0, 1, 1'b1, 16'hABCD, 4'h0, 4'h0};
    vecs[3] = '{16'h00F0, 4'h0, 4'h0, 1, 6, 1'b0, 0, 1'b1, 16'hABCD, 4'h0, 4'h0};
    vecs[4] = '{16'h00F0, 4'h0, 4'h0, 1, 6, 1'b0, 1, 1'b1, 16'h00F0, 4'h0, 4'h0};
    vecs[5] = '{16'h5A67, 4'h1, 4'h4, 2, 6, 1'b0, 1, 1'b1, 16'h5067, 4'h1, 4'h4};
    vecs[6] = '{16'h2468, 4'h0, 4'h0, 2, 6, 1'b1, 1, 1'b1, 16'h2468, 4'h0, 4'h0};
    vecs[7] = '{16'h2468, 4'h0, 4'h0, 1, 6, 1'b1, 0, 1'b1, 16'h2468, 4'h0, 4'h0};

    rst          = 1'b1;
    bus.disp     = 8'hFF;
    bus.disp_sel = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    check("reset.update", 32'(bus.update), 32'h0);
    check_outputs("reset", 1'b0, 16'h0000, 4'h0, 4'h0);
    rst = 1'b0;
    idle(2);

    for (int i = 0; i < 8; i++) begin
      tag = $sformatf("vec%0d", i);
      u0  = upd_total;
      scan(vecs[i].val, vecs[i].dpl, vecs[i].blank, vecs[i].frames, vecs[i].hold,
           vecs[i].glitch);
      idle(4);
      check({tag, ".updates"}, 32'(upd_total - u0), 32'(vecs[i].exp_upd));
      check_outputs(tag, vecs[i].exp_valid, vecs[i].exp_value, vecs[i].exp_dp,
                    vecs[i].exp_err);
    end

    // Reset in the middle of a partly scanned frame.
    drive(4'hE, enc(4'h7, 1'b0, 1'b0), 6);
    drive(4'hD, enc(4'h5, 1'b0, 1'b0), 6);
    #2 rst = 1'b1;
    #1;
    check("midrst.update", 32'(bus.update), 32'h0);
    check_outputs("midrst", 1'b0, 16'h0000, 4'h0, 4'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    u0 = upd_total;
    scan(16'h1357, 4'h0, 4'h0, 1, 6, 1'b0);
    idle(4);
    check("rst1.updates", 32'(upd_total - u0), 32'h0);
    check("rst1.valid", 32'(bus.valid), 32'h0);
    scan(16'h1357, 4'h0, 4'h0, 1, 6, 1'b0);
    idle(4);
    check("rst2.updates", 32'(upd_total - u0), 32'h1);
    check_outputs("rst2", 1'b1, 16'h1357, 4'h0, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
